// File: rtl/dffram_pipe.sv
// Flip-flop RAM with byte enables, in-band error response and optional
// output register; zero-fills itself after reset when ClearOnReset is set.
module dffram_pipe #(
    parameter int          DataW        = 32,
    parameter int          Depth        = 4096,
    parameter int          AddrW        = $clog2(Depth),
    parameter int unsigned OutReg       = 0,
    parameter int unsigned ClearOnReset = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [DataW/8-1:0] be_i,
    input  logic [AddrW-1:0]   addr_i,
    input  logic [DataW-1:0]   wdata_i,
    output logic               gnt_o,
    output logic               rvalid_o,
    output logic [DataW-1:0]   rdata_o,
    output logic               err_o,
    output logic               init_done_o
);

    localparam int NB = DataW / 8;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t           state_q;
    logic             done_q;
    logic [AddrW-1:0] cnt_q;
    logic [DataW-1:0] mem [Depth];

    logic             in_range;
    logic             acc;

    logic             v1_q;
    logic             e1_q;
    logic [DataW-1:0] d1_q;

    assign in_range    = {1'b0, addr_i} < (AddrW+1)'(Depth);
    assign gnt_o       = req_i && (state_q == READY);
    assign acc         = gnt_o && in_range;
    assign init_done_o = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if (ClearOnReset != 0) begin
                state_q <= INIT;
                done_q  <= 1'b0;
            end else begin
                state_q <= READY;
                done_q  <= 1'b1;
            end
            cnt_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (cnt_q == AddrW'(Depth - 1)) begin
                        state_q <= READY;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= READY;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset; the sweep owns the write port while in INIT.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= '0;
        end else if (acc && we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q <= 1'b0;
            e1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= gnt_o;
            e1_q <= gnt_o && !in_range;
            if (acc && !we_i) begin
                d1_q <= mem[addr_i];
            end else begin
                d1_q <= '0;
            end
        end
    end

    if (OutReg != 0) begin : g_oreg
        logic             v2_q;
        logic             e2_q;
        logic [DataW-1:0] d2_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v2_q <= 1'b0;
                e2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                e2_q <= e1_q;
                d2_q <= d1_q;
            end
        end

        assign rvalid_o = v2_q;
        assign err_o    = e2_q;
        assign rdata_o  = d2_q;
    end else begin : g_noreg
        assign rvalid_o = v1_q;
        assign err_o    = e1_q;
        assign rdata_o  = d1_q;
    end

endmodule

// File: tb/tb_dffram_pipe.sv
// Directed table plus reset corner cases and random traffic against a
// byte-masked reference model, over OutReg/Depth/ClearOnReset variants.
module tb_dffram_pipe;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;

    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [3:0]  er;
    logic [3:0]  idn;
    logic [31:0] rd [4];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rel_cyc = 0;
    logic in_rst = 1'b1;

    // expected responses, slot = due cycle mod 4
    int          due [3][4];
    logic [31:0] ed  [3][4];
    logic        ee  [3][4];

    logic [31:0] m16 [16];
    logic [31:0] m12 [12];

    typedef struct {
        logic        w;
        logic [3:0]  b;
        logic [3:0]  a;
        logic [31:0] wd;
        logic [31:0] x16;
        logic [31:0] x12;
        logic        e12;
    } vec_t;

    vec_t tab [15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dffram_pipe #(.DataW(32), .Depth(16), .OutReg(0), .ClearOnReset(1)) d0 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt[0]), .rvalid_o(rv[0]),
        .rdata_o(rd[0]), .err_o(er[0]), .init_done_o(idn[0]));

    dffram_pipe #(.DataW(32), .Depth(16), .OutReg(1), .ClearOnReset(1)) d1 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt[1]), .rvalid_o(rv[1]),
        .rdata_o(rd[1]), .err_o(er[1]), .init_done_o(idn[1]));

    dffram_pipe #(.DataW(32), .Depth(12), .OutReg(0), .ClearOnReset(1)) d2 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt[2]), .rvalid_o(rv[2]),
        .rdata_o(rd[2]), .err_o(er[2]), .init_done_o(idn[2]));

    dffram_pipe #(.DataW(32), .Depth(16), .OutReg(0), .ClearOnReset(0)) d3 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt[3]), .rvalid_o(rv[3]),
        .rdata_o(rd[3]), .err_o(er[3]), .init_done_o(idn[3]));

    task automatic chk(input int i, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL d%0d %s cyc=%0d got=%h want=%h",
                         i, nm, cyc, act, exp);
        end
    endtask

    function automatic logic rdy(input int i);
        if (i == 3) return 1'b1;
        if (in_rst) return 1'b0;
        return (cyc - rel_cyc) >= ((i == 2) ? 12 : 16);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int s;
            logic v;
            logic [31:0] d;
            logic e;
            s = cyc % 4;
            v = (due[i][s] == cyc);
            d = v ? ed[i][s] : 32'h0;
            e = v ? ee[i][s] : 1'b0;
            chk(i, "rvalid", 32'(rv[i]), 32'(v));
            chk(i, "rdata", rd[i], d);
            chk(i, "err", 32'(er[i]), 32'(e));
        end
        for (int i = 0; i < 4; i++)
            chk(i, "init_done", 32'(idn[i]), 32'(rdy(i)));
    end

    task automatic push(input int i, input int c,
                        input logic [31:0] d, input logic e);
        due[i][c % 4] = c;
        ed[i][c % 4]  = d;
        ee[i][c % 4]  = e;
    endtask

    task automatic step(input logic rq, input logic w, input logic [3:0] b,
                        input logic [3:0] a, input logic [31:0] wd,
                        input logic hand, input logic [31:0] h16,
                        input logic [31:0] h12, input logic h12e);
        int c;
        logic e12m;
        logic [31:0] x16, x12;
        logic xe12;
        req = rq; we = w; be = b; addr = a; wdata = wd;
        #1;
        c = cyc;
        for (int i = 0; i < 4; i++)
            chk(i, "gnt", 32'(gnt[i]), 32'(rq && rdy(i)));
        e12m = (a >= 4'd12);
        x16 = w ? 32'h0 : m16[a];
        x12 = 32'h0;
        if (!w && !e12m) x12 = m12[a];
        xe12 = e12m;
        if (hand) begin
            x16 = h16; x12 = h12; xe12 = h12e;
        end
        if (rq && rdy(0)) begin
            push(0, c + 1, x16, 1'b0);
            push(1, c + 2, x16, 1'b0);
            if (w)
                for (int j = 0; j < 4; j++)
                    if (b[j]) m16[a][8*j +: 8] = wd[8*j +: 8];
        end
        if (rq && rdy(2)) begin
            push(2, c + 1, x12, xe12);
            if (w && !e12m)
                for (int j = 0; j < 4; j++)
                    if (b[j]) m12[a][8*j +: 8] = wd[8*j +: 8];
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        rst_ni = 1'b0;
        in_rst = 1'b1;
        req = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int s = 0; s < 4; s++) due[i][s] = -1;
        repeat (hold) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        in_rst = 1'b0;
        rel_cyc = cyc;
        for (int k = 0; k < 16; k++) m16[k] = '0;
        for (int k = 0; k < 12; k++) m12[k] = '0;
    endtask

    initial begin
        //        w     be     addr   wdata          exp16          exp12          e12
        tab[0]  = '{1'b0, 4'hF, 4'd0,  32'h0,        32'h0,         32'h0,         1'b0};
        tab[1]  = '{1'b0, 4'hF, 4'd15, 32'h0,        32'h0,         32'h0,         1'b1};
        tab[2]  = '{1'b1, 4'hF, 4'd5,  32'hAABBCCDD, 32'h0,         32'h0,         1'b0};
        tab[3]  = '{1'b1, 4'h5, 4'd5,  32'h11223344, 32'h0,         32'h0,         1'b0};
        tab[4]  = '{1'b0, 4'h0, 4'd5,  32'h0,        32'hAA22CC44,  32'hAA22CC44,  1'b0};
        tab[5]  = '{1'b1, 4'hF, 4'd3,  32'hDEADBEEF, 32'h0,         32'h0,         1'b0};
        tab[6]  = '{1'b0, 4'h0, 4'd3,  32'h0,        32'hDEADBEEF,  32'hDEADBEEF,  1'b0};
        tab[7]  = '{1'b0, 4'h0, 4'd12, 32'h0,        32'h0,         32'h0,         1'b1};
        tab[8]  = '{1'b1, 4'hF, 4'd15, 32'hCAFEF00D, 32'h0,         32'h0,         1'b1};
        tab[9]  = '{1'b0, 4'h0, 4'd3,  32'h0,        32'hDEADBEEF,  32'hDEADBEEF,  1'b0};
        tab[10] = '{1'b0, 4'h0, 4'd15, 32'h0,        32'hCAFEF00D,  32'h0,         1'b1};
        tab[11] = '{1'b1, 4'h0, 4'd7,  32'h12345678, 32'h0,         32'h0,         1'b0};
        tab[12] = '{1'b0, 4'h0, 4'd7,  32'h0,        32'h0,         32'h0,         1'b0};
        tab[13] = '{1'b1, 4'h8, 4'd7,  32'h99000000, 32'h0,         32'h0,         1'b0};
        tab[14] = '{1'b0, 4'h0, 4'd7,  32'h0,        32'h99000000,  32'h99000000,  1'b0};

        do_reset(3);

        // requests during the sweep must not be granted
        for (int k = 0; k < 16; k++)
            step(1'b1, 1'b0, 4'h0, 4'(k), 32'h0, 1'b0, 0, 0, 1'b0);

        for (int k = 0; k < 16; k++)
            step(1'b1, 1'b0, 4'h0, 4'(k), 32'h0, 1'b0, 0, 0, 1'b0);

        foreach (tab[k])
            step(1'b1, tab[k].w, tab[k].b, tab[k].a, tab[k].wd,
                 1'b1, tab[k].x16, tab[k].x12, tab[k].e12);
        idle(3);

        // reset with responses in flight
        step(1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 1'b0, 0, 0, 1'b0);
        do_reset(2);

        // reset at sweep count 7, then full restart
        for (int k = 0; k < 7; k++)
            step(1'b1, 1'b0, 4'h0, 4'(k), 32'h0, 1'b0, 0, 0, 1'b0);
        do_reset(2);
        for (int k = 0; k < 18; k++)
            step(1'b1, 1'b0, 4'h0, 4'(k % 16), 32'h0, 1'b0, 0, 0, 1'b0);

        for (int k = 0; k < 10000; k++)
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom, 1'b0, 0, 0, 1'b0);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
